// File: rtl/ohc_pkg.sv
// Shared one-hot residue helpers for the RNS channel datapath.
// Functions work on a 64-bit one-hot vector; callers size-cast results.
package ohc_pkg;

   localparam int OHC_DEFAULT_M = 7;
   localparam int OHC_MAX_M     = 64;
   localparam int OHC_MAX_W     = 6;

   typedef logic [OHC_MAX_M-1:0] ohc_t;
   typedef logic [OHC_MAX_W-1:0] idx_t;

   // Modular add of two one-hot codes: cyclic left rotation of base by x.
   function automatic ohc_t ohc_rotl(
      input ohc_t base,
      input ohc_t x,
      input int   m
   );
      ohc_t r;
      idx_t k;
      r = '0;
      for (int j = 0; j < OHC_MAX_M; j++) begin
         for (int i = 0; i < OHC_MAX_M; i++) begin
            if (j < m && i < m) begin
               k    = idx_t'((j - i + m) % m);
               r[j] = r[j] | (base[i] & x[k]);
            end
         end
      end
      return r;
   endfunction

   function automatic idx_t ohc_to_bin(input ohc_t o);
      idx_t r;
      r = '0;
      for (int k = 0; k < OHC_MAX_M; k++) begin
         if (o[k]) r = r | idx_t'(k);
      end
      return r;
   endfunction

endpackage

// File: rtl/ohc_mod_accumulator_bin_to_ohc.sv
// bin_to_ohc: combinational W-bit residue to M-bit one-hot converter.
// The range comparator exists only when OHC_ERR_CHECK_EN is defined.
module bin_to_ohc
   import ohc_pkg::*;
#(
   parameter  int M = OHC_DEFAULT_M,
   localparam int W = $clog2(M)
) (
   input  logic [W-1:0] bin,
   output logic [M-1:0] ohc,
   output logic         illegal
);

   // Out-of-range codes match no bit and yield an all-zero vector.
   always_comb begin
      ohc = '0;
      for (int k = 0; k < M; k++) begin
         ohc[k] = (32'(bin) == k);
      end
   end

`ifdef OHC_ERR_CHECK_EN
   assign illegal = (32'(bin) >= M);
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: rtl/ohc_mod_accumulator.sv
// Two-stage one-hot modulo-M residue accumulator with valid/ready flow.
// Define OHC_ERR_CHECK_EN to flag and skip beats with in_bin >= M.
module ohc_mod_accumulator
   import ohc_pkg::*;
#(
   parameter  int M = OHC_DEFAULT_M,
   localparam int W = $clog2(M)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_bin,
   input  logic         in_clr,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [M-1:0] out_ohc,
   output logic [W-1:0] out_bin,
   output logic         out_err
);

   localparam logic [M-1:0] OHC_ZERO = M'(1);

   logic [M-1:0] x;
   logic         ill;

   logic         s1_valid;
   logic         s1_clr;
   logic         s1_ill;
   logic [M-1:0] s1_x;

   logic         s2_valid;
   logic [M-1:0] acc;
   logic [W-1:0] bin_q;
   logic         err_q;

   logic         s1_adv;
   logic         s2_adv;
   logic [M-1:0] base;
   logic [M-1:0] sum;
   logic [M-1:0] acc_nxt;

   bin_to_ohc #(.M(M)) u_conv (
      .bin     (in_bin),
      .ohc     (x),
      .illegal (ill)
   );

   assign s2_adv   = !s2_valid | out_ready;
   assign s1_adv   = !s1_valid | s2_adv;
   assign in_ready = s1_adv;

   // An illegal beat keeps the running sum and ignores its clear.
   always_comb begin
      base    = s1_clr ? OHC_ZERO : acc;
      sum     = M'(ohc_rotl(ohc_t'(base), ohc_t'(s1_x), M));
      acc_nxt = s1_ill ? acc : sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_clr   <= 1'b0;
         s1_ill   <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_x   <= x;
            s1_clr <= in_clr;
            s1_ill <= ill;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         acc      <= OHC_ZERO;
         bin_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         if (s2_adv) s2_valid <= s1_valid;
         if (s1_valid & s2_adv) begin
            acc   <= acc_nxt;
            bin_q <= W'(ohc_to_bin(ohc_t'(acc_nxt)));
            err_q <= s1_ill;
         end
      end
   end

   assign out_valid = s2_valid;
   assign out_ohc   = acc;
   assign out_bin   = bin_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_ohc_mod_accumulator.sv
// Directed bench for ohc_mod_accumulator: M=7 and M=5 instances.
// Set sel to steer stimulus and observation to one instance.
module tb_ohc_mod_accumulator;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sel = 1'b0;
   logic       dv = 1'b0;
   logic [2:0] db = '0;
   logic       dc = 1'b0;
   logic       ordy = 1'b1;

   logic       iv7, ir7, ov7, oe7;
   logic [6:0] oh7;
   logic [2:0] ob7;
   logic       iv5, ir5, ov5, oe5;
   logic [4:0] oh5;
   logic [2:0] ob5;

   logic        obs_valid, obs_ready, obs_err;
   logic [63:0] obs_ohc;
   logic [2:0]  obs_bin;

   int n_cmp = 0;
   int n_bad = 0;

   int vb[8];
   bit vc[8];
   int ve[8];
   bit vr[8];

   always #5 clk = ~clk;

   assign iv7 = dv & !sel;
   assign iv5 = dv & sel;

   assign obs_valid = sel ? ov5 : ov7;
   assign obs_ready = sel ? ir5 : ir7;
   assign obs_err   = sel ? oe5 : oe7;
   assign obs_ohc   = sel ? 64'(oh5) : 64'(oh7);
   assign obs_bin   = sel ? ob5 : ob7;

   ohc_mod_accumulator #(.M(7)) u7 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv7),
      .in_ready  (ir7),
      .in_bin    (db),
      .in_clr    (dc),
      .out_valid (ov7),
      .out_ready (ordy),
      .out_ohc   (oh7),
      .out_bin   (ob7),
      .out_err   (oe7)
   );

   ohc_mod_accumulator #(.M(5)) u5 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv5),
      .in_ready  (ir5),
      .in_bin    (db),
      .in_clr    (dc),
      .out_valid (ov5),
      .out_ready (ordy),
      .out_ohc   (oh5),
      .out_bin   (ob5),
      .out_err   (oe5)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic vec(input int i, input int b, input bit c,
                      input int e, input bit r);
      vb[i] = b;
      vc[i] = c;
      ve[i] = e;
      vr[i] = r;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Back-to-back beats with out_ready high; beat c shows in cycle c+2.
   task automatic run(input int n);
      for (int c = 0; c <= n + 1; c++) begin
         if (c < n) begin
            dv = 1'b1;
            db = 3'(vb[c]);
            dc = vc[c];
         end else begin
            dv = 1'b0;
            dc = 1'b0;
         end
         @(negedge clk);
         if (c < n) chk("run_rdy", 64'(obs_ready), 64'd1);
         if (c < 2) begin
            chk("run_lat", 64'(obs_valid), 64'd0);
         end else begin
            chk("run_vld", 64'(obs_valid), 64'd1);
            chk("run_bin", 64'(obs_bin), 64'(ve[c-2]));
            chk("run_ohc", obs_ohc, 64'd1 << ve[c-2]);
            chk("run_err", 64'(obs_err), 64'(vr[c-2]));
         end
         step();
      end
      @(negedge clk);
      chk("run_idle", 64'(obs_valid), 64'd0);
      step();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      @(negedge clk);
      chk("rst7_vld", 64'(obs_valid), 64'd0);
      chk("rst7_ohc", obs_ohc, 64'b0000001);
      chk("rst7_bin", 64'(obs_bin), 64'd0);
      chk("rst7_rdy", 64'(obs_ready), 64'd1);
      chk("rst7_err", 64'(obs_err), 64'd0);
      step();

      // 3 then 5: sums 3 and 1 (8 mod 7)
      vec(0, 3, 0, 3, 0);
      vec(1, 5, 0, 1, 0);
      run(2);

      // clear applied on first and third beat
      vec(0, 6, 1, 6, 0);
      vec(1, 6, 0, 5, 0);
      vec(2, 2, 1, 2, 0);
      run(3);

      // backpressure: sum 2, beats 1,2,3 -> 3,5,1
      ordy = 1'b0;
      dv = 1'b1; db = 3'd1;
      @(negedge clk);
      chk("bp0_rdy", 64'(obs_ready), 64'd1);
      chk("bp0_vld", 64'(obs_valid), 64'd0);
      step();
      db = 3'd2;
      @(negedge clk);
      chk("bp1_rdy", 64'(obs_ready), 64'd1);
      chk("bp1_vld", 64'(obs_valid), 64'd0);
      step();
      db = 3'd3;
      for (int c = 2; c < 4; c++) begin
         @(negedge clk);
         chk("bp_stall_rdy", 64'(obs_ready), 64'd0);
         chk("bp_stall_vld", 64'(obs_valid), 64'd1);
         chk("bp_stall_ohc", obs_ohc, 64'b0001000);
         chk("bp_stall_bin", 64'(obs_bin), 64'd3);
         step();
      end
      ordy = 1'b1;
      @(negedge clk);
      chk("bp4_rdy", 64'(obs_ready), 64'd1);
      chk("bp4_ohc", obs_ohc, 64'b0001000);
      step();
      dv = 1'b0;
      @(negedge clk);
      chk("bp5_vld", 64'(obs_valid), 64'd1);
      chk("bp5_bin", 64'(obs_bin), 64'd5);
      step();
      @(negedge clk);
      chk("bp6_vld", 64'(obs_valid), 64'd1);
      chk("bp6_bin", 64'(obs_bin), 64'd1);
      chk("bp6_ohc", obs_ohc, 64'b0000010);
      step();
      @(negedge clk);
      chk("bp7_vld", 64'(obs_valid), 64'd0);
      step();

`ifdef OHC_ERR_CHECK_EN
      // illegal beat keeps sum 4 and flags err
      vec(0, 4, 1, 4, 0);
      vec(1, 7, 1, 4, 1);
      vec(2, 1, 0, 5, 0);
      run(3);
`endif

      sel = 1'b1;
      #1;
      chk("rst5_vld", 64'(obs_valid), 64'd0);
      chk("rst5_ohc", obs_ohc, 64'b00001);
      chk("rst5_bin", 64'(obs_bin), 64'd0);
      step();

      vec(0, 4, 0, 4, 0);
      vec(1, 4, 0, 3, 0);
      vec(2, 4, 0, 2, 0);
      run(3);

      // sum 2 + 1 = 3, then asynchronous reset mid-cycle
      dv = 1'b1; db = 3'd1; dc = 1'b0;
      step();
      step();
      dv = 1'b0;
      @(negedge clk);
      chk("m5_pre_ohc", obs_ohc, 64'b01000);
      chk("m5_pre_vld", 64'(obs_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("m5_arst_ohc", obs_ohc, 64'b00001);
      chk("m5_arst_vld", 64'(obs_valid), 64'd0);
      chk("m5_arst_bin", 64'(obs_bin), 64'd0);
      chk("m5_arst_rdy", 64'(obs_ready), 64'd1);
      step();
      rst_n = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
